// File: rtl/rs_table_pkg.sv
// Shared types and sizing for the unified reservation station.
package rs_table_pkg;
  localparam int RS_DEPTH = 16;
  localparam int NUM_FU   = 3;
  localparam int NUM_WAKE = 3;
  localparam int PREG_W   = 6;
  localparam int FU_MEM   = 2;
  localparam int ROB_W    = 6;
  localparam int IDX_W    = $clog2(RS_DEPTH);
  localparam int CNT_W    = $clog2(RS_DEPTH) + 1;

  typedef struct packed {
    logic              valid;
    logic [3:0]        opcode;
    logic [1:0]        fu;
    logic              ALUSrc;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rs1;
    logic [PREG_W-1:0] rs2;
    logic              src1rdy;
    logic              src2rdy;
    logic [ROB_W-1:0]  robNum;
  } rsEntry;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] tag;
  } wakeBus;

  typedef struct packed {
    logic   valid;
    rsEntry entry;
  } issueStruct;

  // Marks a source ready when any live broadcast carries its tag.
  function automatic rsEntry wake_entry(rsEntry e, wakeBus [NUM_WAKE-1:0] wb);
    rsEntry r;
    r = e;
    for (int w = 0; w < NUM_WAKE; w++) begin
      if (wb[w].valid && wb[w].tag == e.rs1) r.src1rdy = 1'b1;
      if (wb[w].valid && wb[w].tag == e.rs2) r.src2rdy = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/rs_table_if.sv
// Dispatch / wakeup / issue bundle of the reservation station.
interface rs_table_if;
  import rs_table_pkg::*;

  rsEntry                           rsLine_a;
  rsEntry                           rsLine_b;
  logic [NUM_WAKE-1:0]              wake_valid;
  logic [NUM_WAKE-1:0][PREG_W-1:0]  wake_tag;
  logic [NUM_FU-1:0]                fu_ready;
  logic [NUM_FU-1:0]                issue_valid;
  rsEntry [NUM_FU-1:0]              issue_entry;
  logic                             rs_full;
  logic [CNT_W-1:0]                 rs_count;
  logic                             rs_overflow;

  modport master (
    output rsLine_a, rsLine_b, wake_valid, wake_tag, fu_ready,
    input  issue_valid, issue_entry, rs_full, rs_count, rs_overflow
  );
  modport slave (
    input  rsLine_a, rsLine_b, wake_valid, wake_tag, fu_ready,
    output issue_valid, issue_entry, rs_full, rs_count, rs_overflow
  );
endinterface

// File: rtl/rs_select.sv
// Oldest-ready picker: grants the requester with the smallest age rank.
module rs_select #(
  parameter int N     = 16,
  parameter int AGE_W = 4
) (
  input  logic [N-1:0]            req,
  input  logic [N-1:0][AGE_W-1:0] age,
  output logic [N-1:0]            grant,
  output logic                    found
);
  // Ranks of live entries are unique, so at most one requester survives.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req[j] && age[j] < age[i]) grant[i] = 1'b0;
      end
    end
    found = |req;
  end
endmodule

// File: rtl/rs_table.sv
// Unified reservation station: two-wide insert, wakeup snoop, one issue per FU.
module rs_table
  import rs_table_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  rs_table_if.slave rs
);
  logic [RS_DEPTH-1:0]                  ent_vld;
  logic [IDX_W-1:0]                     age [RS_DEPTH];
  rsEntry                               ent [RS_DEPTH];
  logic [CNT_W-1:0]                     count;
  logic                                 overflow;
  logic [NUM_FU-1:0]                    iss_vld;
  rsEntry [NUM_FU-1:0]                  iss_ent;

  wakeBus [NUM_WAKE-1:0]                wb;
  rsEntry                               woke [RS_DEPTH];
  rsEntry                               line_a_w, line_b_w;
  logic [NUM_FU-1:0][RS_DEPTH-1:0]      req, grant;
  logic [NUM_FU-1:0]                    found;
  logic [RS_DEPTH-1:0][IDX_W-1:0]       age_flat;
  logic [RS_DEPTH-1:0]                  granted;
  issueStruct                           pick [NUM_FU];
  logic [IDX_W-1:0]                     pick_age [NUM_FU];
  logic [IDX_W-1:0]                     age_nxt [RS_DEPTH];
  logic [IDX_W-1:0]                     slot_a, slot_b, slot_for_b, rank_a, rank_b, dec;
  logic                                 have_a, have_b, full, wr_a, wr_b;
  logic [CNT_W-1:0]                     n_ins, n_iss, n_keep;

  always_comb begin
    for (int w = 0; w < NUM_WAKE; w++) begin
      wb[w].valid = rs.wake_valid[w];
      wb[w].tag   = rs.wake_tag[w];
    end
  end

  assign line_a_w = wake_entry(rs.rsLine_a, wb);
  assign line_b_w = wake_entry(rs.rsLine_b, wb);

  // Held entries see this cycle's wakeups before selection.
  always_comb begin
    req      = '0;
    age_flat = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      woke[i]     = wake_entry(ent[i], wb);
      age_flat[i] = age[i];
      for (int f = 0; f < NUM_FU; f++) begin
        req[f][i] = ent_vld[i] && woke[i].src1rdy && woke[i].src2rdy &&
                    (woke[i].fu == 2'(f)) && rs.fu_ready[f];
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    rs_select #(.N(RS_DEPTH), .AGE_W(IDX_W)) u_sel (
      .req   (req[f]),
      .age   (age_flat),
      .grant (grant[f]),
      .found (found[f])
    );
  end

  always_comb begin
    granted = '0;
    n_iss   = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      pick[f]     = '0;
      pick_age[f] = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (grant[f][i]) begin
          pick[f].entry = woke[i];
          pick_age[f]   = age[i];
        end
      end
      pick[f].valid         = found[f];
      pick[f].entry.src1rdy = 1'b1;
      pick[f].entry.src2rdy = 1'b1;
      granted = granted | grant[f];
      n_iss   = n_iss + CNT_W'(found[f]);
    end
  end

  // Each survivor moves up by the number of issued entries older than it.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      dec = '0;
      for (int f = 0; f < NUM_FU; f++) begin
        if (found[f] && pick_age[f] < age[i]) dec = dec + IDX_W'(1);
      end
      age_nxt[i] = age[i] - dec;
    end
  end

  always_comb begin
    slot_a = '0;
    slot_b = '0;
    have_a = 1'b0;
    have_b = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!ent_vld[i]) begin
        if (!have_a) begin
          slot_a = IDX_W'(i);
          have_a = 1'b1;
        end else if (!have_b) begin
          slot_b = IDX_W'(i);
          have_b = 1'b1;
        end
      end
    end
  end

  assign full       = (count > CNT_W'(RS_DEPTH - 2));
  assign wr_a       = rs.rsLine_a.valid && !full;
  assign wr_b       = rs.rsLine_b.valid && !full;
  assign slot_for_b = rs.rsLine_a.valid ? slot_b : slot_a;
  assign n_ins      = CNT_W'(wr_a) + CNT_W'(wr_b);
  assign n_keep     = count - n_iss;
  assign rank_a     = n_keep[IDX_W-1:0];
  assign rank_b     = rank_a + IDX_W'(wr_a);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_vld  <= '0;
      for (int i = 0; i < RS_DEPTH; i++) age[i] <= '0;
      count    <= '0;
      overflow <= 1'b0;
      iss_vld  <= '0;
      iss_ent  <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (granted[i]) ent_vld[i] <= 1'b0;
        age[i] <= age_nxt[i];
      end
      if (wr_a) begin
        ent_vld[slot_a] <= 1'b1;
        age[slot_a]     <= rank_a;
      end
      if (wr_b) begin
        ent_vld[slot_for_b] <= 1'b1;
        age[slot_for_b]     <= rank_b;
      end
      count <= count + n_ins - n_iss;
      if (full && (rs.rsLine_a.valid || rs.rsLine_b.valid)) overflow <= 1'b1;
      for (int f = 0; f < NUM_FU; f++) begin
        iss_vld[f] <= pick[f].valid;
        if (pick[f].valid) iss_ent[f] <= pick[f].entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) ent[i] <= woke[i];
    if (wr_a) ent[slot_a]     <= line_a_w;
    if (wr_b) ent[slot_for_b] <= line_b_w;
  end

  assign rs.issue_valid = iss_vld;
  assign rs.issue_entry = iss_ent;
  assign rs.rs_full     = full;
  assign rs.rs_count    = count;
  assign rs.rs_overflow = overflow;
endmodule

// File: tb/tb_rs_table.sv
// Randomised and directed bench for rs_table against an age-ordered queue model.
module tb_rs_table;
  import rs_table_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rs_table_if rs_bus();

  rs_table dut (.clk(clk), .reset(reset), .rs(rs_bus));

  always #5 clk = ~clk;

  rsEntry            held[$];
  logic [NUM_FU-1:0] exp_iv;
  rsEntry            exp_ie [NUM_FU];
  bit                exp_ovf;
  int                n_vec = 0;
  int                n_err = 0;

  function automatic rsEntry mk(bit v, int fu, int rs1, int rs2, bit r1, bit r2, int rob, bit alusrc);
    rsEntry e;
    e = '0;
    e.valid   = v;
    e.opcode  = 4'(rob);
    e.fu      = 2'(fu);
    e.ALUSrc  = alusrc;
    e.rd      = PREG_W'(rob + 20);
    e.rs1     = PREG_W'(rs1);
    e.rs2     = PREG_W'(rs2);
    e.src1rdy = r1;
    e.src2rdy = r2;
    e.robNum  = ROB_W'(rob);
    return e;
  endfunction

  function automatic rsEntry m_wake(rsEntry e);
    rsEntry r;
    r = e;
    for (int w = 0; w < NUM_WAKE; w++) begin
      if (rs_bus.wake_valid[w] && rs_bus.wake_tag[w] == e.rs1) r.src1rdy = 1'b1;
      if (rs_bus.wake_valid[w] && rs_bus.wake_tag[w] == e.rs2) r.src2rdy = 1'b1;
    end
    return r;
  endfunction

  // Queue index is the age rank: oldest entry at the front.
  task automatic model_step();
    rsEntry nq[$];
    bit     picked [RS_DEPTH];
    int     pre;
    pre = held.size();
    for (int k = 0; k < RS_DEPTH; k++) picked[k] = 1'b0;
    foreach (held[k]) held[k] = m_wake(held[k]);
    for (int f = 0; f < NUM_FU; f++) begin
      exp_iv[f] = 1'b0;
      if (rs_bus.fu_ready[f]) begin
        for (int k = 0; k < pre; k++) begin
          if (!picked[k] && held[k].src1rdy && held[k].src2rdy && int'(held[k].fu) == f) begin
            picked[k] = 1'b1;
            exp_iv[f] = 1'b1;
            exp_ie[f] = held[k];
            break;
          end
        end
      end
    end
    nq = {};
    for (int k = 0; k < pre; k++) if (!picked[k]) nq.push_back(held[k]);
    if (pre <= RS_DEPTH - 2) begin
      if (rs_bus.rsLine_a.valid) nq.push_back(m_wake(rs_bus.rsLine_a));
      if (rs_bus.rsLine_b.valid) nq.push_back(m_wake(rs_bus.rsLine_b));
    end else if (rs_bus.rsLine_a.valid || rs_bus.rsLine_b.valid) begin
      exp_ovf = 1'b1;
    end
    held = nq;
  endtask

  task automatic model_clear();
    held    = {};
    exp_iv  = '0;
    exp_ovf = 1'b0;
    for (int f = 0; f < NUM_FU; f++) exp_ie[f] = '0;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_all();
    chk("issue_valid", 64'(rs_bus.issue_valid), 64'(exp_iv));
    for (int f = 0; f < NUM_FU; f++)
      chk($sformatf("issue_entry[%0d]", f), 64'(rs_bus.issue_entry[f]), 64'(exp_ie[f]));
    chk("rs_count", 64'(rs_bus.rs_count), 64'(held.size()));
    chk("rs_full", 64'(rs_bus.rs_full), 64'(held.size() > RS_DEPTH - 2));
    chk("rs_overflow", 64'(rs_bus.rs_overflow), 64'(exp_ovf));
  endtask

  task automatic idle();
    rs_bus.rsLine_a   = '0;
    rs_bus.rsLine_b   = '0;
    rs_bus.wake_valid = '0;
    rs_bus.wake_tag   = '0;
  endtask

  task automatic cycle();
    if (!reset) model_step();
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_clear();
    cmp_all();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    rs_bus.fu_ready = '1;
    model_clear();
    @(negedge clk);
    do_reset();

    // Basic two-wide insert and dual issue.
    rs_bus.fu_ready = 3'b111;
    rs_bus.rsLine_a = mk(1, 0, 1, 2, 1, 1, 0, 0);
    rs_bus.rsLine_b = mk(1, 1, 3, 0, 1, 1, 1, 1);
    cycle();
    chk("basic.count_after_insert", 64'(rs_bus.rs_count), 64'd2);
    chk("basic.no_early_issue", 64'(rs_bus.issue_valid), 64'd0);
    idle();
    cycle();
    chk("basic.issue_valid", 64'(rs_bus.issue_valid), 64'b011);
    chk("basic.model_iv", 64'(exp_iv), 64'b011);
    chk("basic.rob_fu1", 64'(rs_bus.issue_entry[1].robNum), 64'd1);
    chk("basic.count_after_issue", 64'(rs_bus.rs_count), 64'd0);

    // Wakeup of a held load.
    rs_bus.rsLine_a = mk(1, FU_MEM, 12, 0, 0, 1, 2, 0);
    cycle();
    idle();
    rs_bus.wake_valid = 3'b001;
    rs_bus.wake_tag[0] = 6'd12;
    cycle();
    chk("wake.issue_valid", 64'(rs_bus.issue_valid), 64'b100);
    chk("wake.src1rdy", 64'(rs_bus.issue_entry[2].src1rdy), 64'd1);
    idle();

    // Same-cycle bypass into an inserted line.
    rs_bus.rsLine_a = mk(1, 0, 5, 0, 0, 1, 3, 0);
    rs_bus.wake_valid = 3'b010;
    rs_bus.wake_tag[1] = 6'd5;
    cycle();
    chk("bypass.not_same_cycle", 64'(rs_bus.issue_valid), 64'd0);
    idle();
    cycle();
    chk("bypass.issue_valid", 64'(rs_bus.issue_valid), 64'b001);

    // Age ordering on a stalled FU.
    rs_bus.fu_ready = 3'b110;
    for (int k = 0; k < 3; k++) begin
      idle();
      rs_bus.rsLine_a = mk(1, 0, 1, 1, 1, 1, 2 * k, 0);
      cycle();
    end
    idle();
    rs_bus.fu_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("age.rob%0d", k), 64'(rs_bus.issue_entry[0].robNum), 64'(2 * k));
    end

    // Fill to 15 and overflow.
    rs_bus.fu_ready = 3'b000;
    for (int k = 0; k < 7; k++) begin
      rs_bus.rsLine_a = mk(1, k % 3, 40, 41, 0, 0, 2 * k, 0);
      rs_bus.rsLine_b = mk(1, k % 3, 41, 40, 0, 0, 2 * k + 1, 0);
      cycle();
    end
    chk("full.not_at_14", 64'(rs_bus.rs_full), 64'd0);
    idle();
    rs_bus.rsLine_a = mk(1, 0, 40, 40, 0, 0, 14, 0);
    cycle();
    chk("full.rs_full", 64'(rs_bus.rs_full), 64'd1);
    chk("full.count15", 64'(rs_bus.rs_count), 64'd15);
    rs_bus.rsLine_a = mk(1, 0, 1, 1, 1, 1, 15, 0);
    rs_bus.rsLine_b = mk(1, 1, 1, 1, 1, 1, 16, 0);
    cycle();
    chk("ovf.count_held", 64'(rs_bus.rs_count), 64'd15);
    chk("ovf.set", 64'(rs_bus.rs_overflow), 64'd1);
    idle();
    cycle();
    chk("ovf.sticky", 64'(rs_bus.rs_overflow), 64'd1);
    do_reset();
    chk("ovf.cleared", 64'(rs_bus.rs_overflow), 64'd0);

    // Asynchronous reset with six entries held and an issue in flight.
    rs_bus.fu_ready = 3'b000;
    rs_bus.rsLine_a = mk(1, 0, 1, 1, 1, 1, 30, 0);
    rs_bus.rsLine_b = mk(1, 0, 50, 51, 0, 0, 31, 0);
    cycle();
    rs_bus.rsLine_a = mk(1, 1, 50, 51, 0, 0, 32, 0);
    rs_bus.rsLine_b = mk(1, 2, 50, 51, 0, 0, 33, 0);
    cycle();
    idle();
    rs_bus.rsLine_a = mk(1, 0, 51, 50, 0, 0, 34, 0);
    cycle();
    rs_bus.rsLine_a = mk(1, 1, 51, 50, 0, 0, 35, 0);
    rs_bus.rsLine_b = mk(1, 2, 51, 50, 0, 0, 36, 0);
    rs_bus.fu_ready = 3'b111;
    cycle();
    chk("areset.pre_iv", 64'(rs_bus.issue_valid), 64'b001);
    chk("areset.pre_count", 64'(rs_bus.rs_count), 64'd6);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("areset.issue_valid", 64'(rs_bus.issue_valid), 64'd0);
    chk("areset.rs_count", 64'(rs_bus.rs_count), 64'd0);
    chk("areset.rs_full", 64'(rs_bus.rs_full), 64'd0);
    @(negedge clk);
    model_clear();
    cmp_all();
    reset = 1'b0;
    rs_bus.wake_valid = 3'b011;
    rs_bus.wake_tag[0] = 6'd50;
    rs_bus.wake_tag[1] = 6'd51;
    cycle();
    chk("areset.no_issue_after", 64'(rs_bus.issue_valid), 64'd0);
    idle();

    // Randomised traffic.
    for (int c = 0; c < 2400; c++) begin
      if (c % 400 == 399) begin
        do_reset();
      end else begin
        bit allow;
        allow = (held.size() <= RS_DEPTH - 2) || ($urandom_range(0, 49) == 0);
        rs_bus.rsLine_a = '0;
        rs_bus.rsLine_b = '0;
        if (allow && $urandom_range(0, 1) == 1)
          rs_bus.rsLine_a = mk(1, ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2),
                               $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1));
        if (allow && $urandom_range(0, 1) == 1)
          rs_bus.rsLine_b = mk(1, ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2),
                               $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1));
        for (int w = 0; w < NUM_WAKE; w++) begin
          rs_bus.wake_valid[w] = ($urandom_range(0, 3) == 0);
          rs_bus.wake_tag[w]   = PREG_W'($urandom_range(0, 7));
        end
        rs_bus.fu_ready = NUM_FU'($urandom_range(0, 7));
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
